// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and instruction memory geometry shared with the fetch stage
package imem_loader_pkg;
   localparam int IMEM_DEPTH  = 512;
   localparam int IMEM_ADDR_W = 9;
   localparam int INSTR_W     = 32;
   typedef enum logic [1:0] {ST_HALT, ST_LOAD, ST_FLUSH, ST_RUN} state_e;
endpackage

// File: rtl/imem_wr_port_reg.sv
// imem_wr_port_reg: registered imem write port with auto-incrementing write pointer
module imem_wr_port_reg #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              accept_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   output logic              wrap_o
);
   logic              we_q;
   logic [ADDR_W-1:0] addr_q, ptr_q, ptr_d;
   logic [DATA_W-1:0] data_q;
   // pointer reloads on a new command, otherwise steps once per accepted word
   always_comb begin
      ptr_d = load_i ? base_i : accept_i ? ptr_q + (ADDR_W)'(1) : ptr_q;
   end
   // write strobe, address and data registered one cycle after the accept; addr/data hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         ptr_q  <= '0;
      end else begin
         we_q  <= accept_i;
         ptr_q <= ptr_d;
         if (accept_i) begin
            addr_q <= ptr_q;
            data_q <= data_i;
         end
      end
   end
   assign wrap_o = accept_i && (ptr_q == '1);
   assign we_o   = we_q;
   assign addr_o = addr_q;
   assign data_o = data_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: host program loader that writes imem and holds the core in reset while loading
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W   = IMEM_ADDR_W,
   parameter int DATA_W   = INSTR_W,
   parameter bit AUTO_RUN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_start,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W:0]   cmd_len,
   input  logic              cmd_run,
   input  logic              cmd_abort,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   output logic              write_to_imem,
   output logic [ADDR_W-1:0] addr_imem_host,
   output logic [DATA_W-1:0] imem_data,
   output logic              core_rst,
   output logic              busy,
   output logic              load_done,
   output logic              load_err,
   output logic              wrap_seen,
   output logic [ADDR_W:0]   word_count,
   output logic [DATA_W-1:0] checksum
);
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
   state_e            state_q, state_d;
   logic              err_q, err_d, wrap_q, wrap_d, done_q, done_d;
   logic              ready_q, busy_q, core_rst_q;
   logic [ADDR_W:0]   cnt_q, cnt_d, rem_q, rem_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              accept, start_ok, len_ok, wrap_hit;
   assign accept   = ready_q && host_valid;
   assign start_ok = cmd_start && (state_q == ST_HALT || state_q == ST_RUN);
   assign len_ok   = (cmd_len != '0) && (cmd_len <= MAX_LEN);
   imem_wr_port_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr (
      .clk      (clk),
      .rst      (rst),
      .load_i   (start_ok),
      .base_i   (cmd_base),
      .accept_i (accept),
      .data_i   (host_data),
      .we_o     (write_to_imem),
      .addr_o   (addr_imem_host),
      .data_o   (imem_data),
      .wrap_o   (wrap_hit)
   );
   // next state and load bookkeeping; abort outranks completion of the final word
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      wrap_d  = wrap_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      case (state_q)
         ST_HALT, ST_RUN: begin
            if (cmd_start) begin
               cnt_d   = '0;
               sum_d   = '0;
               wrap_d  = 1'b0;
               err_d   = !len_ok;
               rem_d   = cmd_len;
               state_d = len_ok ? ST_LOAD : ST_HALT;
            end else if (state_q == ST_HALT && cmd_run) begin
               state_d = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               cnt_d  = cnt_q + ONE;
               sum_d  = sum_q + host_data;
               rem_d  = rem_q - ONE;
               wrap_d = wrap_q || wrap_hit;
               if (rem_q == ONE) begin
                  state_d = ST_FLUSH;
                  done_d  = 1'b1;
               end
            end
            if (cmd_abort) begin
               state_d = ST_HALT;
               err_d   = 1'b1;
               done_d  = 1'b0;
            end
         end
         ST_FLUSH: state_d = AUTO_RUN ? ST_RUN : ST_HALT;
         default:  state_d = ST_HALT;
      endcase
   end
   // state and status registers; ready/busy/core_rst are registered copies of the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_HALT;
         err_q      <= 1'b0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
         sum_q      <= '0;
         rem_q      <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         core_rst_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         rem_q      <= rem_d;
         ready_q    <= state_d == ST_LOAD;
         busy_q     <= state_d == ST_LOAD || state_d == ST_FLUSH;
         core_rst_q <= state_d != ST_RUN;
      end
   end
   assign host_ready = ready_q;
   assign busy       = busy_q;
   assign core_rst   = core_rst_q;
   assign load_done  = done_q;
   assign load_err   = err_q;
   assign wrap_seen  = wrap_q;
   assign word_count = cnt_q;
   assign checksum   = sum_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenario bench for imem_loader
module tb_imem_loader;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_start = 0, cmd_run = 0, cmd_abort = 0, host_valid = 0;
   logic [8:0]  cmd_base = '0;
   logic [9:0]  cmd_len = '0;
   logic [31:0] host_data = '0;
   logic        host_ready, write_to_imem, core_rst, busy, load_done, load_err, wrap_seen;
   logic [8:0]  addr_imem_host;
   logic [31:0] imem_data, checksum;
   logic [9:0]  word_count;
   int          errors = 0, checks = 0;

   imem_loader #(.ADDR_W(9), .DATA_W(32), .AUTO_RUN(1'b1)) dut (
      .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .cmd_run(cmd_run), .cmd_abort(cmd_abort), .host_valid(host_valid), .host_data(host_data),
      .host_ready(host_ready), .write_to_imem(write_to_imem), .addr_imem_host(addr_imem_host),
      .imem_data(imem_data), .core_rst(core_rst), .busy(busy), .load_done(load_done),
      .load_err(load_err), .wrap_seen(wrap_seen), .word_count(word_count), .checksum(checksum)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [8:0] base, input logic [9:0] len);
      cmd_start = 1; cmd_base = base; cmd_len = len;
      tick();
      cmd_start = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      tick();
      checks++;
      if ({host_ready, write_to_imem, addr_imem_host, imem_data, core_rst, busy, load_done, load_err, wrap_seen, word_count, checksum}
          !== {1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_values: ready=%b we=%b addr=%0d data=%h core_rst=%b busy=%b done=%b err=%b wrap=%b cnt=%0d sum=%h, required core_rst=1 others 0",
                  host_ready, write_to_imem, addr_imem_host, imem_data, core_rst, busy, load_done, load_err, wrap_seen, word_count, checksum);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_basic;
      logic [31:0] w [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      start(9'd0, 10'd4);
      checks++;
      if ({host_ready, busy, core_rst, write_to_imem} !== 4'b1110) begin
         errors++; $display("FAIL basic_enter_load: ready/busy/core_rst/we=%b required 1110", {host_ready, busy, core_rst, write_to_imem});
      end
      host_valid = 1;
      for (int i = 0; i < 4; i++) begin
         host_data = w[i];
         tick();
         checks++;
         if ({write_to_imem, addr_imem_host, imem_data, load_done} !== {1'b1, 9'(i), w[i], i == 3}) begin
            errors++; $display("FAIL basic_write%0d: we=%b addr=%0d data=%h done=%b required we=1 addr=%0d data=%h done=%b",
                               i, write_to_imem, addr_imem_host, imem_data, load_done, i, w[i], i == 3);
         end
      end
      host_valid = 0;
      checks++;
      if ({host_ready, core_rst, word_count, checksum} !== {1'b0, 1'b1, 10'd4, 32'hAA}) begin
         errors++; $display("FAIL basic_flush: ready=%b core_rst=%b cnt=%0d sum=%h required 0 1 4 aa", host_ready, core_rst, word_count, checksum);
      end
      tick();
      checks++;
      if ({load_done, write_to_imem, core_rst, busy, addr_imem_host, imem_data, wrap_seen, load_err} !== {4'b0000, 9'd3, 32'h44, 2'b00}) begin
         errors++; $display("FAIL basic_run: done=%b we=%b core_rst=%b busy=%b addr=%0d data=%h wrap=%b err=%b required 0 0 0 0 3 44 0 0",
                            load_done, write_to_imem, core_rst, busy, addr_imem_host, imem_data, wrap_seen, load_err);
      end
   endtask

   task automatic test_wrap;
      logic [8:0] a [4] = '{9'd510, 9'd511, 9'd0, 9'd1};
      start(9'd510, 10'd4);
      checks++;
      if ({core_rst, host_ready} !== 2'b11) begin
         errors++; $display("FAIL wrap_core_rst_reassert: core_rst/ready=%b required 11", {core_rst, host_ready});
      end
      host_valid = 1;
      for (int i = 0; i < 4; i++) begin
         host_data = 32'h1000 * (i + 1);
         tick();
         checks++;
         if ({write_to_imem, addr_imem_host, imem_data} !== {1'b1, a[i], 32'h1000 * (i + 1)}) begin
            errors++; $display("FAIL wrap_write%0d: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                               i, write_to_imem, addr_imem_host, imem_data, a[i], 32'h1000 * (i + 1));
         end
      end
      host_valid = 0;
      checks++;
      if ({wrap_seen, load_err, load_done, checksum} !== {3'b101, 32'hA000}) begin
         errors++; $display("FAIL wrap_flags: wrap=%b err=%b done=%b sum=%h required 1 0 1 a000", wrap_seen, load_err, load_done, checksum);
      end
      tick();
   endtask

   task automatic test_gapped;
      int writes = 0;
      start(9'd100, 10'd3);
      for (int w = 0; w < 3; w++) begin
         host_valid = 1; host_data = 32'h100 + w;
         tick();
         writes += int'(write_to_imem);
         checks++;
         if ({write_to_imem, addr_imem_host, imem_data} !== {1'b1, 9'(100 + w), 32'h100 + w}) begin
            errors++; $display("FAIL gap_write%0d: we=%b addr=%0d data=%h required 1 %0d %h", w, write_to_imem, addr_imem_host, imem_data, 100 + w, 32'h100 + w);
         end
         host_valid = 0;
         for (int g = 0; g < 2; g++) begin
            tick();
            writes += int'(write_to_imem);
         end
         checks++;
         if (write_to_imem !== 1'b0 || addr_imem_host !== 9'(100 + w)) begin
            errors++; $display("FAIL gap_idle%0d: we=%b addr=%0d required we=0 addr=%0d held", w, write_to_imem, addr_imem_host, 100 + w);
         end
      end
      checks++;
      if (writes != 3 || word_count !== 10'd3 || checksum !== 32'h303) begin
         errors++; $display("FAIL gap_totals: writes=%0d cnt=%0d sum=%h required 3 3 303", writes, word_count, checksum);
      end
   endtask

   task automatic test_bad_len;
      start(9'd5, 10'd0);
      checks++;
      if ({load_err, core_rst, busy, host_ready, write_to_imem} !== 5'b11000) begin
         errors++; $display("FAIL len0: err/core_rst/busy/ready/we=%b required 11000", {load_err, core_rst, busy, host_ready, write_to_imem});
      end
      host_valid = 1; host_data = 32'hDEAD;
      tick(); tick();
      checks++;
      if ({core_rst, host_ready, write_to_imem, word_count} !== {3'b100, 10'd0}) begin
         errors++; $display("FAIL len0_stays_halt: core_rst=%b ready=%b we=%b cnt=%0d required 1 0 0 0", core_rst, host_ready, write_to_imem, word_count);
      end
      host_valid = 0;
      start(9'd5, 10'd512);
      checks++;
      if ({load_err, host_ready, busy} !== 3'b011) begin
         errors++; $display("FAIL len512_ok: err/ready/busy=%b required 011", {load_err, host_ready, busy});
      end
      cmd_abort = 1;
      tick();
      cmd_abort = 0;
      start(9'd5, 10'd513);
      checks++;
      if ({load_err, host_ready, busy, core_rst} !== 4'b1001) begin
         errors++; $display("FAIL len513: err/ready/busy/core_rst=%b required 1001", {load_err, host_ready, busy, core_rst});
      end
   endtask

   task automatic test_abort;
      start(9'd20, 10'd5);
      host_valid = 1;
      for (int i = 0; i < 2; i++) begin
         host_data = 32'hA0 + i;
         tick();
      end
      host_valid = 0; cmd_abort = 1;
      tick();
      cmd_abort = 0;
      checks++;
      if ({host_ready, busy, load_err, core_rst, write_to_imem, word_count, addr_imem_host} !== {5'b00110, 10'd2, 9'd21}) begin
         errors++; $display("FAIL abort: ready=%b busy=%b err=%b core_rst=%b we=%b cnt=%0d addr=%0d required 0 0 1 1 0 2 21",
                            host_ready, busy, load_err, core_rst, write_to_imem, word_count, addr_imem_host);
      end
      start(9'd0, 10'd3);
      checks++;
      if ({load_err, host_ready, word_count} !== {2'b01, 10'd0}) begin
         errors++; $display("FAIL abort_clear: err=%b ready=%b cnt=%0d required 0 1 0", load_err, host_ready, word_count);
      end
      host_valid = 1; host_data = 32'h55; cmd_abort = 1;
      tick();
      host_valid = 0; cmd_abort = 0;
      checks++;
      if ({write_to_imem, addr_imem_host, imem_data, host_ready, load_err} !== {1'b1, 9'd0, 32'h55, 2'b01}) begin
         errors++; $display("FAIL abort_same_cycle: we=%b addr=%0d data=%h ready=%b err=%b required 1 0 55 0 1",
                            write_to_imem, addr_imem_host, imem_data, host_ready, load_err);
      end
      tick();
   endtask

   task automatic test_rst_midload;
      start(9'd7, 10'd3);
      host_valid = 1; host_data = 32'h99;
      tick();
      host_valid = 0;
      #2 rst = 1;
      #1;
      checks++;
      if ({host_ready, write_to_imem, addr_imem_host, imem_data, core_rst, busy, load_done, load_err, wrap_seen, word_count, checksum}
          !== {1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0}) begin
         errors++; $display("FAIL async_rst: ready=%b we=%b addr=%0d data=%h core_rst=%b busy=%b cnt=%0d sum=%h required reset values",
                            host_ready, write_to_imem, addr_imem_host, imem_data, core_rst, busy, word_count, checksum);
      end
      #1 rst = 0;
      tick();
      cmd_run = 1;
      tick();
      cmd_run = 0;
      checks++;
      if ({core_rst, busy} !== 2'b00) begin
         errors++; $display("FAIL run_release: core_rst=%b busy=%b required 0 0", core_rst, busy);
      end
      host_valid = 1; host_data = 32'h77;
      tick(); tick();
      host_valid = 0;
      checks++;
      if ({host_ready, write_to_imem, word_count, core_rst} !== {2'b00, 10'd0, 1'b0}) begin
         errors++; $display("FAIL valid_ignored: ready=%b we=%b cnt=%0d core_rst=%b required 0 0 0 0", host_ready, write_to_imem, word_count, core_rst);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_gapped();
      test_bad_len();
      test_abort();
      test_rst_midload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
